sobel_frame_packer: RTL and testbench

Stream stage between the Sobel filter output and the 32→8 UART narrowing adapter. It takes 16-bit gradient magnitudes and converts each one to an 8-bit byte using a configurable right shift with saturation. It frames each image with a two-byte sync header (0xA5, 0x5A) and flags the last pixel of every frame. This lets the host resynchronise on frame boundaries instead of relying on a raw byte count.

---
 rtl/sobel_frame_packer.sv | 168 ++++++++++++++++
 tb/tb_sobel_frame_packer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_packer.sv
// rtl/sobel_frame_packer.sv - Sobel magnitude to framed byte stream packer
//
// Purpose:
//   Converts 16-bit Sobel gradient magnitudes to bytes using a right shift with
//   saturation. Each frame is prefixed with a two-byte sync header (A5, 5A),
//   and the final pixel of every frame is flagged with last_o.
//
// Ports:
//   clk_i     in   single clock
//   reset_i   in   asynchronous active-high reset
//   valid_i   in   input magnitude valid
//   data_i    in   Sobel magnitude (width_in_p)
//   ready_o   out  input accepted when valid_i & ready_o
//   valid_o   out  output byte valid
//   data_o    out  header or pixel byte (width_out_p)
//   last_o    out  data_o is the final pixel of the frame
//   ready_i   in   downstream ready
//   frames_o  out  completed-frame count, wraps 255 -> 0
module sobel_frame_packer #(
  parameter int width_in_p     = 16,
  parameter int width_out_p    = 8,
  parameter int linewidth_px_p = 480,
  parameter int frame_lines_p  = 480,
  parameter int shift_p        = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   valid_i,
  input  logic [width_in_p-1:0]  data_i,
  output logic                   ready_o,
  output logic                   valid_o,
  output logic [width_out_p-1:0] data_o,
  output logic                   last_o,
  input  logic                   ready_i,
  output logic [7:0]             frames_o
);

  localparam int col_w_lp = (linewidth_px_p > 1) ? $clog2(linewidth_px_p) : 1;
  localparam int row_w_lp = (frame_lines_p > 1) ? $clog2(frame_lines_p) : 1;

  localparam logic [width_in_p-1:0] sat_lim_lp =
    width_in_p'((64'd1 << width_out_p) - 64'd1);
  localparam logic [width_out_p-1:0] hdr0_lp = width_out_p'(8'hA5);
  localparam logic [width_out_p-1:0] hdr1_lp = width_out_p'(8'h5A);

  typedef enum logic [1:0] {
    st_hdr0 = 2'd0,
    st_hdr1 = 2'd1,
    st_pix  = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_valid;
  logic [width_out_p-1:0] r_data;
  logic                   r_last;
  logic [col_w_lp-1:0]    r_col;
  logic [row_w_lp-1:0]    r_row;
  logic [7:0]             r_frames;

  state_t                 w_state_nxt;
  logic                   w_valid_nxt;
  logic [width_out_p-1:0] w_data_nxt;
  logic                   w_last_nxt;
  logic [col_w_lp-1:0]    w_col_nxt;
  logic [row_w_lp-1:0]    w_row_nxt;
  logic [7:0]             w_frames_nxt;

  logic                   w_loadable;
  logic                   w_ready;
  logic                   w_accept;
  logic                   w_col_end;
  logic                   w_row_end;
  logic [width_in_p-1:0]  w_shifted;
  logic [width_out_p-1:0] w_scaled;

  // Output slot can take a new beat when empty or being drained this cycle.
  assign w_loadable = ~r_valid | ready_i;
  assign w_ready    = (r_state == st_pix) & w_loadable;
  assign w_accept   = valid_i & w_ready;

  assign w_col_end = (r_col == col_w_lp'(linewidth_px_p - 1));
  assign w_row_end = (r_row == row_w_lp'(frame_lines_p - 1));

  // Compare at full input width so large magnitudes saturate rather than wrap.
  assign w_shifted = data_i >> shift_p;
  assign w_scaled  = (w_shifted > sat_lim_lp) ? {width_out_p{1'b1}}
                                              : w_shifted[width_out_p-1:0];

  always_comb begin
    w_state_nxt  = r_state;
    w_valid_nxt  = r_valid;
    w_data_nxt   = r_data;
    w_last_nxt   = r_last;
    w_col_nxt    = r_col;
    w_row_nxt    = r_row;
    w_frames_nxt = r_frames;
    if (w_loadable) begin
      // Default when loadable: slot drains and nothing refills it.
      w_valid_nxt = 1'b0;
      w_last_nxt  = 1'b0;
      case (r_state)
        st_hdr0: begin
          w_valid_nxt = 1'b1;
          w_data_nxt  = hdr0_lp;
          w_state_nxt = st_hdr1;
        end
        st_hdr1: begin
          w_valid_nxt = 1'b1;
          w_data_nxt  = hdr1_lp;
          w_state_nxt = st_pix;
        end
        st_pix: begin
          if (valid_i) begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = w_scaled;
            if (w_col_end) begin
              w_col_nxt = '0;
              if (w_row_end) begin
                w_row_nxt    = '0;
                w_last_nxt   = 1'b1;
                w_frames_nxt = r_frames + 8'd1;
                w_state_nxt  = st_hdr0;
              end else begin
                w_row_nxt = r_row + row_w_lp'(1);
              end
            end else begin
              w_col_nxt = r_col + col_w_lp'(1);
            end
          end
        end
        default: begin
          w_state_nxt = st_hdr0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= st_hdr0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_last   <= 1'b0;
      r_col    <= '0;
      r_row    <= '0;
      r_frames <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_valid  <= w_valid_nxt;
      r_data   <= w_data_nxt;
      r_last   <= w_last_nxt;
      r_col    <= w_col_nxt;
      r_row    <= w_row_nxt;
      r_frames <= w_frames_nxt;
    end
  end

  assign ready_o  = w_ready;
  assign valid_o  = r_valid;
  assign data_o   = r_data;
  assign last_o   = r_last;
  assign frames_o = r_frames;

  // valid_i only matters in the pixel state with a loadable slot.
  logic w_unused;
  assign w_unused = w_accept;

endmodule

// File: tb/tb_sobel_frame_packer.sv
// tb/tb_sobel_frame_packer.sv - self-checking bench for sobel_frame_packer
module tb_sobel_frame_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: 4 px/line, 2 lines/frame, shift 4
  logic        reset_i;
  logic        valid_i;
  logic [15:0] data_i;
  logic        ready_o;
  logic        valid_o;
  logic [7:0]  data_o;
  logic        last_o;
  logic        ready_i;
  logic [7:0]  frames_o;

  sobel_frame_packer #(
    .width_in_p(16), .width_out_p(8), .linewidth_px_p(4),
    .frame_lines_p(2), .shift_p(4)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .data_i(data_i),
    .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o), .last_o(last_o),
    .ready_i(ready_i), .frames_o(frames_o)
  );

  // Wrap instance: 2 px/line, 1 line/frame
  logic        w2_reset;
  logic        w2_valid_i;
  logic [15:0] w2_data_i;
  logic        w2_ready_o;
  logic        w2_valid_o;
  logic [7:0]  w2_data_o;
  logic        w2_last_o;
  logic        w2_ready_i;
  logic [7:0]  w2_frames_o;

  sobel_frame_packer #(
    .width_in_p(16), .width_out_p(8), .linewidth_px_p(2),
    .frame_lines_p(1), .shift_p(4)
  ) dut_wrap (
    .clk_i(clk), .reset_i(w2_reset), .valid_i(w2_valid_i), .data_i(w2_data_i),
    .ready_o(w2_ready_o), .valid_o(w2_valid_o), .data_o(w2_data_o), .last_o(w2_last_o),
    .ready_i(w2_ready_i), .frames_o(w2_frames_o)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] log_q[$];
  int         pix_cnt;
  int         hdr_left;
  int         frames_exp;
  bit         exp_full;
  bit         prev_stall;
  logic [7:0] prev_d;
  logic       prev_l;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Magnitude / 16, clamped to a byte.
  function automatic logic [7:0] ref_scale(input logic [15:0] d);
    int unsigned s;
    s = int'(d) / 16;
    return (s > 255) ? 8'hFF : s[7:0];
  endfunction

  task automatic model_reset();
    exp_q.delete();
    log_q.delete();
    exp_q.push_back('{8'hA5, 1'b0});
    exp_q.push_back('{8'h5A, 1'b0});
    pix_cnt    = 0;
    hdr_left   = 2;
    frames_exp = 0;
    exp_full   = 0;
    prev_stall = 0;
  endtask

  // Called just after a negedge; drives inputs, checks, returns after next negedge.
  task automatic cycle(input logic v, input logic [15:0] d, input logic r, output bit acc);
    bit    loadable;
    beat_t e;
    acc = 0;
    valid_i = v;
    data_i  = d;
    ready_i = r;
    #1;
    check("valid_o", valid_o, exp_full);
    check("frames_o", frames_o, 16'(frames_exp % 256));
    loadable = !exp_full || r;
    if (hdr_left > 0) check("ready_hdr", ready_o, 0);
    else              check("ready_pix", ready_o, loadable);
    if (prev_stall) begin
      check("stable_data", data_o, prev_d);
      check("stable_last", last_o, prev_l);
    end
    if (exp_full && r) begin
      if (exp_q.size() == 0) begin
        check("queue_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("data_o", data_o, e.d);
        check("last_o", last_o, e.l);
        log_q.push_back(data_o);
      end
    end
    prev_stall = exp_full && !r;
    prev_d     = data_o;
    prev_l     = last_o;
    if (loadable) begin
      if (hdr_left > 0) begin
        hdr_left--;
        exp_full = 1;
      end else if (v) begin
        acc = 1;
        pix_cnt++;
        exp_q.push_back('{ref_scale(d), pix_cnt == 8});
        if (pix_cnt == 8) begin
          pix_cnt = 0;
          hdr_left = 2;
          frames_exp++;
          exp_q.push_back('{8'hA5, 1'b0});
          exp_q.push_back('{8'h5A, 1'b0});
        end
        exp_full = 1;
      end else begin
        exp_full = 0;
      end
    end
    @(negedge clk);
  endtask

  // rmode 0: ready_i=1; rmode 1: random ready_i
  task automatic send(input logic [15:0] d, input int rmode);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    while (!acc && n < 200) begin
      cycle(1'b1, d, (rmode == 0) ? 1'b1 : 1'($urandom % 2), acc);
      n++;
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 1'b1, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1;
    valid_i = 0;
    ready_i = 0;
    @(negedge clk);
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_last", last_o, 0);
    check("rst_frames", frames_o, 0);
    check("rst_ready", ready_o, 0);
    @(negedge clk);
    reset_i = 0;
    model_reset();
  endtask

  logic [7:0]  t1_exp [11];
  logic [15:0] sat_in [6];
  logic [7:0]  sat_exp [6];

  initial begin
    int n;
    int seen;
    reset_i = 1; valid_i = 0; data_i = 0; ready_i = 0;
    w2_reset = 1; w2_valid_i = 0; w2_data_i = 0; w2_ready_i = 0;
    t1_exp  = '{8'hA5, 8'h5A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hA5};
    sat_in  = '{16'h0FF0, 16'h0FFF, 16'h1000, 16'hFFFF, 16'h0123, 16'h000F};
    sat_exp = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h12, 8'h00};

    // Basic frame
    do_reset();
    for (int k = 1; k <= 8; k++) send(16'(16 * k), 0);
    idle(4);
    check("t1_len", 16'(log_q.size() >= 11), 1);
    for (int i = 0; i < 11 && i < log_q.size(); i++) check("t1_seq", log_q[i], t1_exp[i]);
    check("t1_frames", frames_o, 1);

    // Saturation
    do_reset();
    for (int i = 0; i < 6; i++) send(sat_in[i], 0);
    idle(3);
    for (int i = 0; i < 6; i++) begin
      if (log_q.size() > i + 2) check("sat_byte", log_q[i+2], sat_exp[i]);
      else check("sat_missing", 0, 1);
    end

    // Backpressure over 3 frames
    do_reset();
    n = 0;
    while (frames_exp < 3 && n < 100) begin
      send(16'($urandom), 1);
      n++;
    end
    idle(6);
    check("bp_frames", frames_o, 3);
    check("bp_drained", 16'(exp_q.size()), 0);

    // Input starvation
    do_reset();
    n = 0;
    while (frames_exp < 2 && n < 100) begin
      idle($urandom_range(0, 3));
      send(16'($urandom), 0);
      n++;
    end
    idle(4);
    check("starve_frames", frames_o, 2);

    // Asynchronous reset mid-line after 5 pixels
    do_reset();
    for (int i = 0; i < 5; i++) send(16'($urandom), 0);
    check("mid_valid_before", valid_o, 1);
    #2 reset_i = 1;
    #1;
    check("mid_valid_drop", valid_o, 0);
    check("mid_frames", frames_o, 0);
    @(negedge clk);
    reset_i = 0;
    model_reset();
    n = 0;
    while (frames_exp < 1 && n < 20) begin
      send(16'($urandom), 0);
      n++;
    end
    idle(3);
    check("mid_frames_after", frames_o, 1);

    // frames_o wrap on the 2x1 instance
    reset_i = 1;
    @(negedge clk);
    w2_valid_i = 1;
    w2_ready_i = 1;
    w2_reset = 0;
    seen = 0;
    n = 0;
    while (seen < 257 && n < 2000) begin
      w2_data_i = 16'($urandom);
      @(negedge clk);
      #1;
      if (w2_valid_o && w2_last_o) begin
        seen++;
        check("wrap_frames", w2_frames_o, 16'(seen % 256));
      end
      n++;
    end
    check("wrap_done", 16'(seen), 257);
    check("wrap_final", w2_frames_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
